// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                         |
// | Purpose  : Opcodes, default widths and entry layout shared by the ALU path |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package alu_pkg;

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_MUL    = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd3;
    localparam logic [2:0] OP_LOGIC0 = 3'd4;
    localparam logic [2:0] OP_LOGIC1 = 3'd5;
    localparam logic [2:0] OP_LOGIC2 = 3'd6;
    localparam logic [2:0] OP_CUSTOM = 3'd7;

    localparam int unsigned ALU_WIDTH = 4;
    localparam int unsigned OPCODE_W  = 3;
    localparam int unsigned CARRY_W   = 1;

    // Stored entry is {result[2*width], carry, opcode}.
    function automatic int unsigned entry_width(input int unsigned width);
        return 2 * width + CARRY_W + OPCODE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_fifo_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_fifo_ptr                                                    |
// | Purpose  : Write/read pointers and occupancy level for the result FIFO     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_fifo_ptr #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [LVL_W-1:0] level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Push and pop together leave the level unchanged.
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign level_o  = level_q;
    assign full_o   = (level_q == LVL_W'(DEPTH));
    assign empty_o  = (level_q == '0);

endmodule
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_result_fifo                                                 |
// | Purpose  : FWFT FIFO capturing ALU {result, carry, opcode} with zero flag; |
// |            ALU_STATS_EN adds a saturating carry counter (carry_cnt).       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2*WIDTH-1:0]         in_result,
    input  logic                       in_carry,
    input  logic [OPCODE_W-1:0]        in_opcode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH-1:0]         out_result,
    output logic                       out_carry,
    output logic [OPCODE_W-1:0]        out_opcode,
    output logic                       out_zero,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop_err
`ifdef ALU_STATS_EN
    ,
    output logic [CNT_W-1:0]           carry_cnt
`endif
);

    localparam int unsigned ENTRY_W = entry_width(WIDTH);
    localparam int unsigned PTR_W   = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               drop_err_q;

    // Illegal configurations elaborate to an empty marker block.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_check
    end

    assign push = in_valid && !full;
    assign pop  = out_ready && !empty;

    alu_fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push),
        .pop_i    (pop),
        .wr_ptr_o (wr_ptr),
        .rd_ptr_o (rd_ptr),
        .level_o  (level),
        .full_o   (full),
        .empty_o  (empty)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= {in_result, in_carry, in_opcode};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_err_q <= 1'b0;
        end else if (in_valid && full) begin
            drop_err_q <= 1'b1;
        end
    end

    assign head = mem_q[rd_ptr];
    assign {out_result, out_carry, out_opcode} = head;
    assign out_zero  = (out_result == '0);
    assign out_valid = !empty;
    assign in_ready  = !full;
    assign drop_err  = drop_err_q;

`ifdef ALU_STATS_EN
    logic [CNT_W-1:0] carry_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_cnt_q <= '0;
        end else if (push && in_carry && (carry_cnt_q != '1)) begin
            carry_cnt_q <= carry_cnt_q + 1'b1;
        end
    end

    assign carry_cnt = carry_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_result_fifo                                              |
// | Purpose  : Directed self-checking bench for alu_result_fifo                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_alu_result_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_result;
    logic       in_carry;
    logic [2:0] in_opcode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_carry;
    logic [2:0] out_opcode;
    logic       out_zero;
    logic [2:0] level;
    logic       drop_err;
`ifdef ALU_STATS_EN
    logic [1:0] carry_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_result_fifo #(
        .WIDTH (4),
        .DEPTH (4),
        .CNT_W (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_carry   (in_carry),
        .in_opcode  (in_opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_opcode (out_opcode),
        .out_zero   (out_zero),
        .level      (level),
        .drop_err   (drop_err)
`ifdef ALU_STATS_EN
        ,
        .carry_cnt  (carry_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_result = 8'h00;
        in_carry  = 1'b0;
        in_opcode = 3'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_in(input logic v, input logic [7:0] r, input logic c, input logic [2:0] op);
        in_valid  = v;
        in_result = r;
        in_carry  = c;
        in_opcode = op;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || level !== 3'd0 || drop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b lvl=%0d drop=%b want 1 0 0 0",
                     in_ready, out_valid, level, drop_err);
        end
        set_in(1'b1, 8'h0F, 1'b0, 3'd0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_bypass: got out_valid=%b want 0", out_valid);
        end
        tick();
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 8'h0F || out_zero !== 1'b0 ||
            out_carry !== 1'b0 || out_opcode !== 3'd0 || level !== 3'd1) begin
            n_fail++;
            $display("FAIL first_push: got vld=%b res=%h z=%b c=%b op=%0d lvl=%0d want 1 0f 0 0 0 1",
                     out_valid, out_result, out_zero, out_carry, out_opcode, level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL first_pop: got vld=%b lvl=%0d want 0 0", out_valid, level);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp_r [4];
        logic       exp_c [4];
        logic [2:0] exp_o [4];
        exp_r[0] = 8'hA1; exp_c[0] = 1'b1; exp_o[0] = 3'd1;
        exp_r[1] = 8'hB2; exp_c[1] = 1'b0; exp_o[1] = 3'd2;
        exp_r[2] = 8'hC3; exp_c[2] = 1'b1; exp_o[2] = 3'd5;
        exp_r[3] = 8'hD4; exp_c[3] = 1'b0; exp_o[3] = 3'd7;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, exp_r[i], exp_c[i], exp_o[i]);
            tick();
        end
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        n_checks++;
        if (level !== 3'd4 || in_ready !== 1'b0 || drop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: got lvl=%0d rdy=%b drop=%b want 4 0 0", level, in_ready, drop_err);
        end
        set_in(1'b1, 8'hFF, 1'b1, 3'd3);
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_no_passthru: got in_ready=%b want 0", in_ready);
        end
        out_ready = 1'b0;
        tick();
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        n_checks++;
        if (drop_err !== 1'b1 || level !== 3'd4) begin
            n_fail++;
            $display("FAIL overflow: got drop=%b lvl=%0d want 1 4", drop_err, level);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_result !== exp_r[i] || out_carry !== exp_c[i] ||
                out_opcode !== exp_o[i]) begin
                n_fail++;
                $display("FAIL drain_%0d: got vld=%b res=%h c=%b op=%0d want 1 %h %b %0d",
                         i, out_valid, out_result, out_carry, out_opcode, exp_r[i], exp_c[i], exp_o[i]);
            end
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || level !== 3'd0 || drop_err !== 1'b1) begin
            n_fail++;
            $display("FAIL drained: got vld=%b lvl=%0d drop=%b want 0 0 1", out_valid, level, drop_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        do_reset();
        set_in(1'b1, 8'h10, 1'b0, 3'd4);
        tick();
        set_in(1'b1, 8'h11, 1'b0, 3'd4);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp = 8'h10 + 8'(i);
            set_in(1'b1, 8'h12 + 8'(i), 1'b0, 3'd4);
            n_checks++;
            if (out_valid !== 1'b1 || out_result !== exp) begin
                n_fail++;
                $display("FAIL b2b_head_%0d: got vld=%b res=%h want 1 %h", i, out_valid, out_result, exp);
            end
            tick();
            n_checks++;
            if (level !== 3'd2) begin
                n_fail++;
                $display("FAIL b2b_level_%0d: got %0d want 2", i, level);
            end
        end
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        out_ready = 1'b0;
        n_checks++;
        if (drop_err !== 1'b0 || out_result !== 8'h1A) begin
            n_fail++;
            $display("FAIL b2b_end: got drop=%b res=%h want 0 1a", drop_err, out_result);
        end
    endtask

    task automatic test_zero();
        do_reset();
        set_in(1'b1, 8'h00, 1'b1, 3'd7);
        tick();
        set_in(1'b1, 8'h05, 1'b0, 3'd2);
        n_checks++;
        if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_result !== 8'h00 ||
            out_carry !== 1'b1 || out_opcode !== 3'd7) begin
            n_fail++;
            $display("FAIL zero_head: got vld=%b z=%b res=%h c=%b op=%0d want 1 1 00 1 7",
                     out_valid, out_zero, out_result, out_carry, out_opcode);
        end
        tick();
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        n_checks++;
        if (out_zero !== 1'b1 || level !== 3'd2) begin
            n_fail++;
            $display("FAIL zero_hold: got z=%b lvl=%0d want 1 2", out_zero, level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_zero !== 1'b0 || out_result !== 8'h05) begin
            n_fail++;
            $display("FAIL zero_clear: got z=%b res=%h want 0 05", out_zero, out_result);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 8'h30 + 8'(i), 1'b0, 3'd1);
            tick();
        end
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (level !== 3'd3 || drop_err !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got lvl=%0d drop=%b want 3 1", level, drop_err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || drop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got lvl=%0d vld=%b rdy=%b drop=%b want 0 0 1 0",
                     level, out_valid, in_ready, drop_err);
        end
    endtask

`ifdef ALU_STATS_EN
    task automatic test_stats();
        logic [1:0] exp [5];
        exp[0] = 2'd1; exp[1] = 2'd2; exp[2] = 2'd3; exp[3] = 2'd3; exp[4] = 2'd3;
        do_reset();
        n_checks++;
        if (carry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL stats_reset: got %0d want 0", carry_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 8'h40 + 8'(i), 1'b1, 3'd0);
            tick();
            n_checks++;
            if (carry_cnt !== exp[i]) begin
                n_fail++;
                $display("FAIL stats_cnt_%0d: got %0d want %0d", i, carry_cnt, exp[i]);
            end
        end
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        out_ready = 1'b0;
        do_reset();
        set_in(1'b1, 8'h01, 1'b0, 3'd0);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 3'd0);
        n_checks++;
        if (carry_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL stats_nocarry: got %0d want 0", carry_cnt);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_result = 8'h00;
        in_carry  = 1'b0;
        in_opcode = 3'd0;
        tick();
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_zero();
        test_midreset();
`ifdef ALU_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
